i2c_cmd_arbiter: RTL and testbench
==================================

# i2c_cmd_arbiter

Round-robin arbiter that shares the single 24-bit I2C write engine (`{slave_addr, sub_addr, data}`, GO/END/ACK handshake) between several requesters: boot-time audio codec and HDMI transmitter config sequencers, and run-time register pokes such as volume changes. It owns NACK retry and transaction timeout, so requesters see only a done/err result per command. It sits between the requesters and the I2C controller, in the `iCLK` domain.

## Interface

- `N_REQ`, 3: number of requesters, 2..8.
- `MAX_RETRY`, 3: re-issues after NACK before reporting error, 0..15.
- `TIMEOUT_CYC`, 2_000_000: `iCLK` cycles allowed from GO to END.
- `iCLK`, in, 1: clock.
- `iRST_N`, in, 1: reset, asynchronous, active-low.
- `req`, in, N_REQ: level request per requester.
- `req_data`, in, 24*N_REQ: command for requester i, held in bits [24i+23:24i].
- `grant`, out, N_REQ: one-hot owner of the current transaction; level.
- `done`, out, N_REQ: 1-cycle pulse when the owner's command was ACKed.
- `err`, out, N_REQ: 1-cycle pulse on retries exhausted or timeout.
- `busy`, out, 1: high in any state other than IDLE.
- `eng_data`, out, 24: command to the engine.
- `eng_go`, out, 1: level start signal to the engine.
- `eng_end`, in, 1: engine finished; stays high while `eng_go` is high.
- `eng_ack`, in, 1: valid with `eng_end`; 0 = ACK, 1 = NACK.

## Operation

- **States:** IDLE, WAIT, GAP.
- **IDLE:**
  - When any `req` bit is high, the winner is the first set bit searching upward from `rr_ptr`, wrapping round.
  - In the same edge: latch `req_data` slice into `eng_data`, set `grant`, set `eng_go`=1, clear `retry_cnt` and `tmo_cnt`, then go to WAIT.
  - Set `rr_ptr` to winner+1 modulo N_REQ.
- **WAIT:** `tmo_cnt` increments every cycle.
  - `eng_end`=1 and `eng_ack`=0: pulse `done[owner]`, drop `eng_go`, set `next`=IDLE, go to GAP.
  - `eng_end`=1, `eng_ack`=1 and `retry_cnt`<MAX_RETRY: increment `retry_cnt`, drop `eng_go`, set `next`=WAIT, go to GAP. `eng_data` is unchanged.
  - `eng_end`=1, `eng_ack`=1 and `retry_cnt`=MAX_RETRY: pulse `err[owner]`, drop `eng_go`, set `next`=IDLE, go to GAP.
  - `tmo_cnt`=TIMEOUT_CYC-1 without `eng_end`: pulse `err[owner]`, drop `eng_go`, set `next`=IDLE, go to GAP. Timeout takes priority if `eng_end` rises in the same cycle.
- **GAP:** waits for `eng_end`=0, which is needed to re-arm the engine.
  - If `next`=WAIT: reassert `eng_go`, clear `tmo_cnt`, go to WAIT.
  - If `next`=IDLE: clear `grant`, go to IDLE.
- **Requester rules:**
  - Hold `req` and `req_data` stable from assertion until done/err.
  - `req` dropped while granted: the transaction still completes and the pulse is still issued.
  - `req` dropped while not granted: the request is withdrawn silently.
  - `req` still high after done/err: treated as a new command, re-arbitrated fairly.
- **Widths:**
  - `retry_cnt`: 4 bits.
  - `tmo_cnt`: $clog2(TIMEOUT_CYC) bits; saturating is not needed because it is cleared on every issue.
  - `rr_ptr`: $clog2(N_REQ) bits, wraps from N_REQ-1 to 0.

## Timing

- **Reset values:** state IDLE, `eng_go`=0, `eng_data`=0, `grant`=0, `done`=0, `err`=0, `busy`=0, `rr_ptr`=0. Reset mid-transaction drops `eng_go` immediately (async).
- **Issue latency:** `req` sampled high at edge k in IDLE gives `eng_go`=1 and `grant` valid after edge k.
- **Result latency:** `eng_end` sampled at edge m gives `done`/`err` high for cycle m..m+1 and `eng_go`=0 after edge m.
- **Back-to-back minimum:** END, then GAP for at least 1 cycle, then IDLE for 1 cycle, then the next GO. Minimum 2 cycles between GO deassert and next GO.
- `grant` is stable from issue until GAP exits to IDLE; the `done`/`err` pulse always occurs while `grant` is still set.
- At most one of `done` and `err` is high in any cycle, and only for the owner bit.

## Structure

- Package `i2c_arb_pkg`:
  - `I2C_CMD_W`=24.
  - State enum `arb_state_t` {IDLE, WAIT, GAP}.
  - Result enum {RES_OK, RES_NACK, RES_TMO} for debug.
- Sub-module `i2c_rr_pick`: combinational round-robin priority picker. Inputs `req`, `rr_ptr`; outputs one-hot `win` and `win_idx`. Instantiated once.

## Test plan

- **Single request:** `req`=3'b001, data 24'h34_0C00, engine ACKs 40 cycles after GO. Expect `eng_data`=24'h340C00, `eng_go` one cycle after `req`, then `done[0]` single pulse, `grant` cleared, `busy`=0.
- **Fairness:** all three `req` held high continuously, engine always ACKs. Expect grant order 0,1,2,0,1,2 and exactly one done per grant.
- **NACK retry:** MAX_RETRY=3, engine NACKs twice then ACKs. Expect 3 GO pulses with identical `eng_data` and `done` (not `err`). NACK 4 times: expect 4 GO pulses, then `err`.
- **Timeout:** TIMEOUT_CYC=100, engine never asserts END. Expect `err[owner]` at cycle 100 after GO, `eng_go` low, next requester granted.
- **Stuck END / reset:** `eng_end` held high for 10 cycles after GO drops. Expect no re-GO until it falls. Assert `iRST_N` low mid-WAIT: expect all outputs 0 asynchronously and `rr_ptr`=0 afterwards.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C command arbiter.
package i2c_arb_pkg;

  // One engine command: {slave_addr, sub_addr, data}.
  localparam int I2C_CMD_W = 24;
  localparam int RETRY_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GAP
  } arb_state_t;

  // Outcome of one engine attempt, decoded in WAIT.
  typedef enum logic [1:0] {
    RES_OK,
    RES_NACK,
    RES_TMO
  } arb_res_t;

  // Counter width that never collapses to zero bits.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module i2c_rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int PTR_W = cnt_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] win,
  output logic [PTR_W-1:0] win_idx
);

  int   w_idx;
  logic w_found;

  // Scan N_REQ positions starting at rr_ptr; the first hit wins.
  always_comb begin
    // NOTE: every output and temporary gets a default before the loop so no path leaves one unassigned (no latch).
    win     = '0;
    win_idx = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = (int'(rr_ptr) + k) % N_REQ;
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        win[w_idx]   = 1'b1;
        win_idx      = PTR_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one 24-bit I2C write engine between N_REQ requesters, with NACK retry and timeout.
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic                       iCLK,
  input  logic                       iRST_N,
  input  logic [N_REQ-1:0]           req,
  input  logic [I2C_CMD_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           done,
  output logic [N_REQ-1:0]           err,
  output logic                       busy,
  output logic [I2C_CMD_W-1:0]       eng_data,
  output logic                       eng_go,
  input  logic                       eng_end,
  input  logic                       eng_ack
);

  localparam int PTR_W = cnt_width(N_REQ);
  localparam int TMO_W = cnt_width(TIMEOUT_CYC);

  arb_state_t           r_state;
  arb_state_t           r_next;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [RETRY_W-1:0]   r_retry_cnt;
  logic [TMO_W-1:0]     r_tmo_cnt;
  logic [N_REQ-1:0]     r_grant;
  logic [N_REQ-1:0]     r_done;
  logic [N_REQ-1:0]     r_err;
  logic                 r_busy;
  logic                 r_eng_go;
  logic [I2C_CMD_W-1:0] r_eng_data;

  logic [N_REQ-1:0]     w_win;
  logic [PTR_W-1:0]     w_win_idx;
  logic [PTR_W-1:0]     w_ptr_next;
  logic                 w_tmo_hit;
  logic                 w_attempt_over;
  arb_res_t             w_res;

  i2c_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (req),
    .rr_ptr  (r_rr_ptr),
    .win     (w_win),
    .win_idx (w_win_idx)
  );

  assign w_ptr_next     = (w_win_idx == PTR_W'(N_REQ - 1)) ? '0 : w_win_idx + PTR_W'(1);
  assign w_tmo_hit      = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign w_attempt_over = w_tmo_hit || eng_end;

  // Classify the current attempt; timeout outranks a same-cycle END.
  always_comb begin
    w_res = RES_OK;
    if (w_tmo_hit)    w_res = RES_TMO;
    else if (eng_ack) w_res = RES_NACK;
  end

  // Arbitration FSM with all outputs registered; async reset drops eng_go at once.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= IDLE;
      r_next      <= IDLE;
      r_rr_ptr    <= '0;
      r_retry_cnt <= '0;
      r_tmo_cnt   <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_busy      <= 1'b0;
      r_eng_go    <= 1'b0;
      r_eng_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every branch reads pre-edge register values.
      r_done <= '0;
      r_err  <= '0;
      unique case (r_state)
        IDLE: begin
          if (|req) begin
            r_eng_data  <= req_data[w_win_idx*I2C_CMD_W +: I2C_CMD_W];
            r_grant     <= w_win;
            r_eng_go    <= 1'b1;
            r_busy      <= 1'b1;
            r_retry_cnt <= '0;
            r_tmo_cnt   <= '0;
            r_rr_ptr    <= w_ptr_next;
            r_state     <= WAIT;
          end
        end

        WAIT: begin
          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          if (w_attempt_over) begin
            r_eng_go <= 1'b0;
            r_state  <= GAP;
            r_next   <= IDLE;
            unique case (w_res)
              RES_OK:  r_done <= r_grant;
              RES_TMO: r_err  <= r_grant;
              default: begin
                if (r_retry_cnt < RETRY_W'(MAX_RETRY)) begin
                  r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
                  r_next      <= WAIT;
                end else begin
                  r_err <= r_grant;
                end
              end
            endcase
          end
        end

        GAP: begin
          // The engine only re-arms once END has fallen.
          if (!eng_end) begin
            if (r_next == WAIT) begin
              r_eng_go  <= 1'b1;
              r_tmo_cnt <= '0;
              r_state   <= WAIT;
            end else begin
              r_grant <= '0;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant    = r_grant;
  assign done     = r_done;
  assign err      = r_err;
  assign busy     = r_busy;
  assign eng_go   = r_eng_go;
  assign eng_data = r_eng_data;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Randomized self-checking bench for i2c_cmd_arbiter with a behavioural arbitration model.
module tb_i2c_cmd_arbiter;

  localparam int N   = 3;
  localparam int MR  = 3;
  localparam int TMO = 100;

  logic            iCLK = 1'b0;
  logic            iRST_N = 1'b0;
  logic [N-1:0]    req = '0;
  logic [24*N-1:0] req_data = '0;
  logic [N-1:0]    grant, done, err;
  logic            busy;
  logic [23:0]     eng_data;
  logic            eng_go;
  logic            eng_end = 1'b0;
  logic            eng_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;      // model's round-robin start position
  int go_cnt   = 0;      // GO rising edges seen by the monitor
  logic go_prev = 1'b0;
  logic [23:0] cmd [N];

  i2c_cmd_arbiter #(
    .N_REQ       (N),
    .MAX_RETRY   (MR),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .eng_data (eng_data),
    .eng_go   (eng_go),
    .eng_end  (eng_end),
    .eng_ack  (eng_ack)
  );

  always #5 iCLK = ~iCLK;

  // Count GO pulses independently of the transaction driver.
  always @(negedge iCLK) begin
    if (eng_go && !go_prev) go_cnt++;
    go_prev = eng_go;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_req(input logic [N-1:0] rq);
    req = rq;
    for (int i = 0; i < N; i++) req_data[24*i +: 24] = cmd[i];
  endtask

  // One arbitration slot. n_nack NACKs precede the final attempt, which ACKs or times out.
  task automatic run_txn(input logic [N-1:0] rq, input int n_nack, input bit tmo,
                         input bit tmo_end, input int dly, input int stuck, input bit drop_req);
    int w, nacks, st, go_start, exp_gos;
    bit fin, nack_now;
    logic [N-1:0] exp_g;
    drive_req(rq);
    go_start = go_cnt;
    @(posedge iCLK); #1;
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && rq[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    if (w < 0) begin
      check("idle_grant", grant, 0);
      check("idle_go", eng_go, 0);
      check("idle_busy", busy, 0);
      return;
    end
    m_ptr = (w + 1) % N;
    exp_g = '0;
    exp_g[w] = 1'b1;
    check("issue_grant", grant, exp_g);
    check("issue_go", eng_go, 1);
    check("issue_data", eng_data, cmd[w]);
    check("issue_busy", busy, 1);
    if (drop_req) req = '0;
    fin = 0;
    nacks = 0;
    while (!fin) begin
      nack_now = (nacks < n_nack);
      st = stuck;
      if (!nack_now && tmo) begin
        repeat (TMO - 1) begin @(posedge iCLK); #1; end
        check("tmo_pre_go", eng_go, 1);
        check("tmo_pre_err", err, 0);
        if (tmo_end) begin eng_end = 1'b1; eng_ack = 1'b0; end
        else st = 0;
        @(posedge iCLK); #1;
        check("tmo_err", err, exp_g);
        check("tmo_done", done, 0);
        check("tmo_go", eng_go, 0);
        fin = 1;
      end else begin
        repeat (dly) begin @(posedge iCLK); #1; end
        eng_end = 1'b1;
        eng_ack = nack_now;
        @(posedge iCLK); #1;
        check("res_go", eng_go, 0);
        check("res_grant", grant, exp_g);
        if (!nack_now) begin
          check("ack_done", done, exp_g);
          check("ack_err", err, 0);
          fin = 1;
        end else if (nacks == MR) begin
          check("nack_err", err, exp_g);
          check("nack_done", done, 0);
          fin = 1;
        end else begin
          check("retry_pulse", done | err, 0);
        end
        nacks++;
      end
      for (int j = 0; j < st; j++) begin
        @(posedge iCLK); #1;
        check("gap_go", eng_go, 0);
        check("gap_pulse", done | err, 0);
        check("gap_grant", grant, exp_g);
      end
      eng_end = 1'b0;
      eng_ack = 1'b0;
      @(posedge iCLK); #1;
      if (fin) begin
        check("end_grant", grant, 0);
        check("end_busy", busy, 0);
        check("end_pulse", done | err, 0);
      end else begin
        check("rego_go", eng_go, 1);
        check("rego_data", eng_data, cmd[w]);
        check("rego_grant", grant, exp_g);
      end
    end
    exp_gos = (n_nack > MR) ? MR + 1 : n_nack + 1;
    check("go_count", go_cnt - go_start, exp_gos);
  endtask

  initial begin
    for (int i = 0; i < N; i++) cmd[i] = 24'($urandom);
    #2;
    check("rst_grant", grant, 0);
    check("rst_go", eng_go, 0);
    check("rst_data", eng_data, 0);
    check("rst_busy", busy, 0);
    check("rst_pulse", done | err, 0);
    @(posedge iCLK); #1;
    iRST_N = 1'b1;

    // Fairness: all requesters held, engine always ACKs.
    for (int t = 0; t < 6; t++) begin
      check("fair_order_model", m_ptr, t % N);
      run_txn(3'b111, 0, 0, 0, 5, 0, 0);
    end

    // Single request, ACK 40 cycles after GO.
    cmd[0] = 24'h340C00;
    run_txn(3'b001, 0, 0, 0, 40, 0, 1);
    // Two NACKs then ACK; four NACKs then error.
    run_txn(3'b010, 2, 0, 0, 3, 1, 0);
    run_txn(3'b010, 4, 0, 0, 2, 0, 1);
    // Timeout alone, timeout colliding with END, ACK one cycle before timeout.
    run_txn(3'b100, 0, 1, 0, 0, 0, 1);
    run_txn(3'b011, 1, 1, 1, 4, 2, 0);
    run_txn(3'b001, 0, 0, 0, TMO - 2, 0, 1);
    // END stuck high 10 cycles after a NACK holds off the re-GO.
    run_txn(3'b100, 1, 0, 0, 3, 10, 1);
    run_txn(3'b000, 0, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < N; i++) cmd[i] = 24'($urandom);
      run_txn(N'($urandom_range(0, 7)), $urandom_range(0, 5), ($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 1)), $urandom_range(0, 20), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    // Async reset mid-WAIT, then the pointer must restart at requester 0.
    cmd[0] = 24'hA5A5A5;
    drive_req(3'b001);
    @(posedge iCLK); #1;
    check("pre_rst_grant", grant, 3'b001);
    req = '0;
    repeat (5) @(posedge iCLK);
    #3;
    iRST_N = 1'b0;
    #1;
    check("async_go", eng_go, 0);
    check("async_grant", grant, 0);
    check("async_busy", busy, 0);
    check("async_data", eng_data, 0);
    @(posedge iCLK); #1;
    iRST_N = 1'b1;
    m_ptr = 0;
    run_txn(3'b111, 0, 0, 0, 2, 0, 0);
    run_txn(3'b111, 0, 0, 0, 2, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
